// File: rtl/dffram_req_ctrl_if.sv
// Request/response channel between a bus/CPU adapter and the DFFRAM front-end.
// The master drives requests and accepts responses; the slave is the controller.
interface dffram_req_ctrl_if #(
    parameter int A_WIDTH = 7
) ();
    logic               req_valid;
    logic               req_ready;
    logic [3:0]         req_we;
    logic [A_WIDTH-1:0] req_addr;
    logic [31:0]        req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_rdata;
    logic               rsp_wr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_wr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_wr
    );
endinterface

// File: rtl/dffram_req_ctrl.sv
// Valid/ready front-end for a DFFRAM128x32 port: issues requests to the RAM and
// returns in-order responses through a credit-limited response FIFO.
module dffram_req_ctrl #(
    parameter int A_WIDTH   = 7,
    parameter int RSP_DEPTH = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    dffram_req_ctrl_if.slave   bus,
    output logic               EN0,
    output logic [3:0]         WE0,
    output logic [A_WIDTH-1:0] A0,
    output logic [31:0]        Di0,
    input  logic [31:0]        Do0
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } rsp_t;

    logic             issue;
    logic             pop;
    logic             push;
    logic             req_ready;
    logic             rsp_valid;
    logic             inflight;
    logic             inflight_wr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W:0]   occupancy;
    rsp_t             mem [RSP_DEPTH];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check counts the response still inside the RAM, so the capture
    // push in the following cycle always finds a free FIFO slot.
    always_comb begin
        occupancy = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
        req_ready = RST_N && (occupancy < (CNT_W + 1)'(RSP_DEPTH));
    end

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && bus.rsp_ready;
    assign issue     = bus.req_valid && req_ready;
    assign push      = inflight;

    assign EN0 = issue;
    assign WE0 = issue ? bus.req_we : 4'b0000;
    assign A0  = bus.req_addr;
    assign Di0 = bus.req_wdata;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = mem[rd_ptr].rdata;
    assign bus.rsp_wr    = mem[rd_ptr].wr;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            inflight    <= 1'b0;
            inflight_wr <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            inflight    <= issue;
            inflight_wr <= issue && (bus.req_we != 4'b0000);
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage has no reset; count gates every read of it, so
    // stale entries are never visible.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= '{wr: inflight_wr, rdata: Do0};
    end
endmodule

// File: tb/tb_dffram_req_ctrl.sv
// Directed bench for dffram_req_ctrl with a behavioural DFFRAM128x32 model
// (registered read-before-write, Do0 = 0 after a cycle with EN0 low).
module tb_dffram_req_ctrl;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN0;
    logic [3:0]  WE0;
    logic [6:0]  A0;
    logic [31:0] Di0;
    logic [31:0] Do0 = '0;

    int checks = 0;
    int errors = 0;

    dffram_req_ctrl_if #(.A_WIDTH(7)) bus ();

    dffram_req_ctrl #(.A_WIDTH(7), .RSP_DEPTH(2)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus),
        .EN0   (EN0),
        .WE0   (WE0),
        .A0    (A0),
        .Di0   (Di0),
        .Do0   (Do0)
    );

    always #5 CLK = ~CLK;

    // Unwritten words read back as a known address-derived pattern.
    function automatic logic [31:0] init_word(input logic [6:0] a);
        return 32'hC0DE_0000 | {25'd0, a};
    endfunction

    logic [31:0]  ram [128];
    logic [127:0] touched = '0;

    always @(posedge CLK) begin
        logic [31:0] cur;
        if (EN0) begin
            cur = touched[A0] ? ram[A0] : init_word(A0);
            Do0 <= cur;
            for (int b = 0; b < 4; b++)
                if (WE0[b]) cur[8*b +: 8] = Di0[8*b +: 8];
            ram[A0]     <= cur;
            touched[A0] <= 1'b1;
        end else begin
            Do0 <= '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] we, input logic [6:0] a,
                         input logic [31:0] d);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic expect_rsp(input string tag, input logic wr, input logic [31:0] rdata);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " rsp_wr"}, 32'(bus.rsp_wr), 32'(wr));
        check({tag, " rsp_rdata"}, bus.rsp_rdata, rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N         = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(1'b1, 4'hF, 7'h03, 32'h0BAD_F00D);

        // 1. Reset with req_valid held high
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst EN0", 32'(EN0), 32'd0);
            check("rst WE0", 32'(WE0), 32'd0);
            check("rst req_ready", 32'(bus.req_ready), 32'd0);
            check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        RST_N = 1'b1;
        drive(1'b0, 4'h0, 7'h00, 32'h0);
        cyc();
        check("idle rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("idle req_ready", 32'(bus.req_ready), 32'd1);

        // 2. Write then read-after-write
        drive(1'b1, 4'hF, 7'h05, 32'hDEAD_BEEF);
        #1;
        check("wr EN0", 32'(EN0), 32'd1);
        check("wr WE0", 32'(WE0), 32'hF);
        check("wr A0", 32'(A0), 32'h05);
        check("wr Di0", Di0, 32'hDEAD_BEEF);
        cyc();
        drive(1'b1, 4'h0, 7'h05, 32'h0);
        #1;
        check("rd WE0", 32'(WE0), 32'd0);
        check("rd EN0", 32'(EN0), 32'd1);
        check("raw rsp not yet", 32'(bus.rsp_valid), 32'd0);
        cyc();
        drive(1'b0, 4'h0, 7'h00, 32'h0);
        expect_rsp("raw wr", 1'b1, init_word(7'h05));
        cyc();
        expect_rsp("raw rd", 1'b0, 32'hDEAD_BEEF);
        cyc();
        check("raw drained", 32'(bus.rsp_valid), 32'd0);

        // 3. Byte lanes
        drive(1'b1, 4'hF, 7'h7F, 32'h1122_3344);
        cyc();
        drive(1'b1, 4'b0101, 7'h7F, 32'hAABB_CCDD);
        cyc();
        drive(1'b1, 4'h0, 7'h7F, 32'h0);
        expect_rsp("lane w1", 1'b1, init_word(7'h7F));
        cyc();
        drive(1'b0, 4'h0, 7'h00, 32'h0);
        expect_rsp("lane w2", 1'b1, 32'h1122_3344);
        cyc();
        expect_rsp("lane rd", 1'b0, 32'h11BB_33DD);
        cyc();
        check("lane drained", 32'(bus.rsp_valid), 32'd0);

        // 4. Streaming: 64 back-to-back reads, addresses 0x10..0x4F
        for (int i = 0; i < 66; i++) begin
            if (i < 64) drive(1'b1, 4'h0, 7'(8'h10 + i), 32'h0);
            else        drive(1'b0, 4'h0, 7'h00, 32'h0);
            #1;
            if (i < 64) check("stream req_ready", 32'(bus.req_ready), 32'd1);
            if (i >= 2) expect_rsp("stream", 1'b0, init_word(7'(8'h10 + i - 2)));
            cyc();
        end
        check("stream drained", 32'(bus.rsp_valid), 32'd0);

        // 5. Backpressure: reads 0x60..0x63 with rsp_ready low
        bus.rsp_ready = 1'b0;
        drive(1'b1, 4'h0, 7'h60, 32'h0);
        #1;
        check("bp acc0", 32'(bus.req_ready), 32'd1);
        cyc();
        drive(1'b1, 4'h0, 7'h61, 32'h0);
        #1;
        check("bp acc1", 32'(bus.req_ready), 32'd1);
        cyc();
        drive(1'b1, 4'h0, 7'h62, 32'h0);
        #1;
        check("bp stall0", 32'(bus.req_ready), 32'd0);
        check("bp stall EN0", 32'(EN0), 32'd0);
        cyc();
        check("bp stall1", 32'(bus.req_ready), 32'd0);
        expect_rsp("bp held", 1'b0, init_word(7'h60));
        cyc();
        check("bp stall2", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        #1;
        check("bp release ready", 32'(bus.req_ready), 32'd1);
        expect_rsp("bp r0", 1'b0, init_word(7'h60));
        cyc();
        drive(1'b1, 4'h0, 7'h63, 32'h0);
        #1;
        check("bp acc3", 32'(bus.req_ready), 32'd1);
        expect_rsp("bp r1", 1'b0, init_word(7'h61));
        cyc();
        drive(1'b0, 4'h0, 7'h00, 32'h0);
        expect_rsp("bp r2", 1'b0, init_word(7'h62));
        cyc();
        expect_rsp("bp r3", 1'b0, init_word(7'h63));
        cyc();
        check("bp drained", 32'(bus.rsp_valid), 32'd0);

        // 6. Reset with one response buffered and one in flight
        bus.rsp_ready = 1'b0;
        drive(1'b1, 4'hF, 7'h20, 32'h1234_5678);
        cyc();
        drive(1'b1, 4'h0, 7'h30, 32'h0);
        cyc();
        drive(1'b0, 4'h0, 7'h00, 32'h0);
        check("mid buffered", 32'(bus.rsp_valid), 32'd1);
        RST_N = 1'b0;
        #1;
        check("mid rst req_ready", 32'(bus.req_ready), 32'd0);
        cyc();
        check("mid rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        RST_N         = 1'b1;
        bus.rsp_ready = 1'b1;
        cyc();
        check("post rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        drive(1'b1, 4'h0, 7'h20, 32'h0);
        #1;
        check("post rst ready", 32'(bus.req_ready), 32'd1);
        cyc();
        drive(1'b0, 4'h0, 7'h00, 32'h0);
        check("post rst pending", 32'(bus.rsp_valid), 32'd0);
        cyc();
        expect_rsp("post rst rd", 1'b0, 32'h1234_5678);
        cyc();
        check("post rst drained", 32'(bus.rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
